// File: rtl/misr_multi.sv
`default_nettype none
// ============================================================================
//  Module   : misr_multi
//  Purpose  : Multi-channel MISR. Per-channel holding registers align skewed
//             CUT output streams into beats, and each beat is folded into a
//             signature with a programmable feedback polynomial and seed.
//  Revision : 1.0 - initial release
// ============================================================================
module misr_multi #(
    parameter int NUM_CHANNELS        = 4,
    parameter int CUT_MSG_BITS        = 32,
    parameter int SIGNATURE_BITS      = 32,
    parameter     POLY                = 32'h04C11DB7,
    parameter     SEED                = 32'd0,
    parameter int MAX_OUTPUTS_TO_HASH = 32,
    parameter int LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS-1:0]              cut_req_val,
    input  logic [NUM_CHANNELS*CUT_MSG_BITS-1:0] cut_req_msg,
    output logic [NUM_CHANNELS-1:0]              cut_req_rdy,
    input  logic                                 lbist_req_val,
    input  logic [LBIST_MSG_BITS:0]              lbist_req_msg,
    output logic                                 lbist_req_rdy,
    output logic                                 lbist_resp_val,
    output logic [SIGNATURE_BITS-1:0]            lbist_resp_msg,
    input  logic                                 lbist_resp_rdy
);

    // Beat geometry: the concatenated beat is zero-padded to whole signature slices
    localparam int BEAT_BITS  = NUM_CHANNELS * CUT_MSG_BITS;
    localparam int NUM_SLICES = (BEAT_BITS + SIGNATURE_BITS - 1) / SIGNATURE_BITS;
    localparam int PAD_BITS   = NUM_SLICES * SIGNATURE_BITS;

    localparam logic [SIGNATURE_BITS-1:0] C_POLY = SIGNATURE_BITS'(POLY);
    localparam logic [SIGNATURE_BITS-1:0] C_SEED = SIGNATURE_BITS'(SEED);
    localparam logic [LBIST_MSG_BITS:0]   C_MAX  = (LBIST_MSG_BITS+1)'(MAX_OUTPUTS_TO_HASH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HASH = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                      r_state;
    state_t                                      w_state_nxt;
    logic [SIGNATURE_BITS-1:0]                   r_sig;
    logic [LBIST_MSG_BITS:0]                     r_count;
    logic [LBIST_MSG_BITS:0]                     r_n;
    logic [NUM_CHANNELS-1:0]                     r_held;
    logic [NUM_CHANNELS-1:0][CUT_MSG_BITS-1:0]   r_hold;

    logic                                        w_req_fire;
    logic                                        w_resp_fire;
    logic [NUM_CHANNELS-1:0]                     w_cut_fire;
    logic                                        w_beat_done;
    logic                                        w_last_beat;
    logic [LBIST_MSG_BITS:0]                     w_n_clamped;
    logic [BEAT_BITS-1:0]                        w_beat;
    logic [PAD_BITS-1:0]                         w_beat_pad;
    logic [SIGNATURE_BITS-1:0]                   w_fold;

    // One LFSR shift of the signature with conditional polynomial feedback
    function automatic logic [SIGNATURE_BITS-1:0] f_step(input logic [SIGNATURE_BITS-1:0] s);
        logic [SIGNATURE_BITS-1:0] shifted;
        shifted = {s[SIGNATURE_BITS-2:0], 1'b0};
        return s[SIGNATURE_BITS-1] ? (shifted ^ C_POLY) : shifted;
    endfunction

    assign w_req_fire   = lbist_req_val & lbist_req_rdy;
    assign w_resp_fire  = lbist_resp_val & lbist_resp_rdy;
    assign w_cut_fire   = cut_req_val & cut_req_rdy;
    // A beat is complete once every channel has either been captured or is firing now
    assign w_beat_done  = (r_state == S_HASH) && (&(r_held | w_cut_fire));
    assign w_last_beat  = ((r_count + 1'b1) == r_n);
    assign w_n_clamped  = (lbist_req_msg > C_MAX) ? C_MAX : lbist_req_msg;
    assign lbist_resp_msg = r_sig;

    // Assemble the beat (held data wins over live input) and fold it to signature width
    always_comb begin
        w_beat = '0;
        w_fold = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_beat[i*CUT_MSG_BITS +: CUT_MSG_BITS] =
                r_held[i] ? r_hold[i] : cut_req_msg[i*CUT_MSG_BITS +: CUT_MSG_BITS];
        end
        w_beat_pad = PAD_BITS'(w_beat);
        for (int k = 0; k < NUM_SLICES; k++) begin
            w_fold = w_fold ^ w_beat_pad[k*SIGNATURE_BITS +: SIGNATURE_BITS];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs, all derived from registered state
    always_comb begin
        w_state_nxt    = r_state;
        cut_req_rdy    = '0;
        lbist_req_rdy  = 1'b0;
        lbist_resp_val = 1'b0;
        case (r_state)
            S_IDLE: begin
                lbist_req_rdy = 1'b1;
                if (w_req_fire) begin
                    w_state_nxt = (w_n_clamped == '0) ? S_DONE : S_HASH;
                end
            end
            S_HASH: begin
                cut_req_rdy = ~r_held;
                if (w_beat_done && w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                lbist_resp_val = 1'b1;
                if (w_resp_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Signature, beat counter and run length
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig   <= C_SEED;
            r_count <= '0;
            r_n     <= '0;
        end else if (w_req_fire) begin
            r_sig   <= C_SEED;
            r_count <= '0;
            r_n     <= w_n_clamped;
        end else if (w_beat_done) begin
            r_sig   <= f_step(r_sig) ^ w_fold;
            r_count <= r_count + 1'b1;
        end
    end

    // Per-channel holding registers absorb arrival skew within a beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_held <= '0;
            r_hold <= '0;
        end else if (w_beat_done) begin
            r_held <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_cut_fire[i]) begin
                    r_held[i] <= 1'b1;
                    r_hold[i] <= cut_req_msg[i*CUT_MSG_BITS +: CUT_MSG_BITS];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_misr_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_misr_multi
//  Purpose  : Directed self-checking bench for misr_multi in a 2x8-bit
//             channel, 8-bit signature configuration (POLY=8'h1D, SEED=0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_misr_multi;

    logic        clk;
    logic        reset;
    logic [1:0]  cut_req_val;
    logic [15:0] cut_req_msg;
    logic [1:0]  cut_req_rdy;
    logic        lbist_req_val;
    logic [5:0]  lbist_req_msg;
    logic        lbist_req_rdy;
    logic        lbist_resp_val;
    logic [7:0]  lbist_resp_msg;
    logic        lbist_resp_rdy;

    int n_checks = 0;
    int n_errors = 0;

    misr_multi #(
        .NUM_CHANNELS       (2),
        .CUT_MSG_BITS       (8),
        .SIGNATURE_BITS     (8),
        .POLY               (8'h1D),
        .SEED               (8'h00),
        .MAX_OUTPUTS_TO_HASH(32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cut_req_val   (cut_req_val),
        .cut_req_msg   (cut_req_msg),
        .cut_req_rdy   (cut_req_rdy),
        .lbist_req_val (lbist_req_val),
        .lbist_req_msg (lbist_req_msg),
        .lbist_req_rdy (lbist_req_rdy),
        .lbist_resp_val(lbist_resp_val),
        .lbist_resp_msg(lbist_resp_msg),
        .lbist_resp_rdy(lbist_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a start request for n beats; returns with the DUT past IDLE
    task automatic start_run(input logic [5:0] n);
        lbist_req_val = 1'b1;
        lbist_req_msg = n;
        tick();
        lbist_req_val = 1'b0;
        lbist_req_msg = '0;
    endtask

    // Drive one beat on both channels in the same cycle
    task automatic beat(input logic [7:0] ch0, input logic [7:0] ch1);
        cut_req_val = 2'b11;
        cut_req_msg = {ch1, ch0};
        tick();
        cut_req_val = 2'b00;
        cut_req_msg = '0;
    endtask

    task automatic accept_resp();
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        cut_req_val    = '0;
        cut_req_msg    = '0;
        lbist_req_val  = 1'b0;
        lbist_req_msg  = '0;
        lbist_resp_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_req_rdy",  32'(lbist_req_rdy),  32'h1);
        check("rst_cut_rdy",  32'(cut_req_rdy),    32'h0);
        check("rst_resp_val", 32'(lbist_resp_val), 32'h0);
        check("rst_resp_msg", 32'(lbist_resp_msg), 32'h00);

        // Test 1: single beat, with stray CUT data alongside the request
        lbist_req_val = 1'b1;
        lbist_req_msg = 6'd1;
        cut_req_val   = 2'b11;
        cut_req_msg   = {8'h55, 8'hAA};
        tick();
        lbist_req_val = 1'b0;
        cut_req_val   = 2'b00;
        check("t1_req_rdy_hash", 32'(lbist_req_rdy), 32'h0);
        check("t1_cut_rdy_hash", 32'(cut_req_rdy),   32'h3);
        beat(8'h01, 8'h02);
        check("t1_resp_val", 32'(lbist_resp_val), 32'h1);
        check("t1_resp_msg", 32'(lbist_resp_msg), 32'h03);
        check("t1_cut_rdy_done", 32'(cut_req_rdy), 32'h0);
        accept_resp();
        check("t1_idle_req_rdy", 32'(lbist_req_rdy), 32'h1);

        // Test 2: feedback through the polynomial
        start_run(6'd2);
        beat(8'h80, 8'h00);
        check("t2_sig_beat1", 32'(dut.r_sig),       32'h80);
        check("t2_val_mid",   32'(lbist_resp_val),  32'h0);
        beat(8'h00, 8'h00);
        check("t2_resp_val", 32'(lbist_resp_val), 32'h1);
        check("t2_resp_msg", 32'(lbist_resp_msg), 32'h1D);

        // Test 5: backpressure holds the response stable
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_bp_val", 32'(lbist_resp_val), 32'h1);
            check("t5_bp_msg", 32'(lbist_resp_msg), 32'h1D);
        end
        accept_resp();
        check("t5_idle_val",     32'(lbist_resp_val), 32'h0);
        check("t5_idle_req_rdy", 32'(lbist_req_rdy),  32'h1);

        // Test 3: skewed channel arrival; held channel ignores new data
        start_run(6'd1);
        cut_req_val = 2'b01;
        cut_req_msg = {8'h00, 8'h01};
        tick();
        cut_req_msg = {8'h00, 8'hFF};
        for (int c = 0; c < 2; c++) begin
            check("t3_skew_rdy", 32'(cut_req_rdy),    32'h2);
            check("t3_skew_val", 32'(lbist_resp_val), 32'h0);
            tick();
        end
        check("t3_skew_rdy_last", 32'(cut_req_rdy), 32'h2);
        cut_req_val = 2'b11;
        cut_req_msg = {8'h02, 8'hFF};
        tick();
        cut_req_val = 2'b00;
        check("t3_resp_val", 32'(lbist_resp_val), 32'h1);
        check("t3_resp_msg", 32'(lbist_resp_msg), 32'h03);
        accept_resp();

        // Test 4: zero-length run, stray CUT valid alongside
        lbist_req_val = 1'b1;
        lbist_req_msg = 6'd0;
        cut_req_val   = 2'b11;
        cut_req_msg   = {8'h12, 8'h34};
        tick();
        lbist_req_val = 1'b0;
        cut_req_val   = 2'b00;
        check("t4_resp_val", 32'(lbist_resp_val), 32'h1);
        check("t4_resp_msg", 32'(lbist_resp_msg), 32'h00);
        check("t4_cut_rdy",  32'(cut_req_rdy),    32'h0);
        accept_resp();

        // Back-to-back three-beat run at full throughput
        start_run(6'd3);
        cut_req_val = 2'b11;
        cut_req_msg = {8'h40, 8'h81};
        tick();
        cut_req_msg = {8'h0F, 8'hFF};
        tick();
        cut_req_msg = {8'h01, 8'h00};
        tick();
        cut_req_val = 2'b00;
        check("t7_resp_val", 32'(lbist_resp_val), 32'h1);
        check("t7_resp_msg", 32'(lbist_resp_msg), 32'hDF);
        accept_resp();

        // Test 6: reset mid-run discards everything
        start_run(6'd4);
        beat(8'h11, 8'h22);
        beat(8'h33, 8'h44);
        cut_req_val = 2'b01;
        cut_req_msg = {8'h00, 8'h77};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cut_req_val = 2'b00;
        check("t6_rst_req_rdy",  32'(lbist_req_rdy),  32'h1);
        check("t6_rst_cut_rdy",  32'(cut_req_rdy),    32'h0);
        check("t6_rst_resp_val", 32'(lbist_resp_val), 32'h0);
        check("t6_rst_resp_msg", 32'(lbist_resp_msg), 32'h00);
        check("t6_rst_held",     32'(dut.r_held),     32'h0);
        start_run(6'd1);
        beat(8'h01, 8'h02);
        check("t6_resp_val", 32'(lbist_resp_val), 32'h1);
        check("t6_resp_msg", 32'(lbist_resp_msg), 32'h03);
        accept_resp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
